// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin arbiter sharing one registered 16x16 multiplier among NREQ requesters
// Optional MUL_ARB_STATS_EN adds per-requester saturating accept counters on stat_cnt.
module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_product
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_cnt
`endif
);

    logic            w_en;
    logic            w_any_valid;
    logic            w_xfer;
    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_ptr_next;
    logic [15:0]     w_a;
    logic [15:0]     w_b;
    logic [31:0]     w_product;

    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id1;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic            r_v1;

    // The whole pipeline and the pointer advance together; a stalled response freezes everything.
    assign w_en        = !rsp_valid || rsp_ready;
    assign w_any_valid = |req_valid;
    assign w_xfer      = w_en && w_any_valid;

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && req_valid[(int'(r_ptr) + off) % NREQ]) begin
                w_found = 1'b1;
                w_grant = IDW'((int'(r_ptr) + off) % NREQ);
            end
        end
    end

    assign w_a        = req_a[16*w_grant +: 16];
    assign w_b        = req_b[16*w_grant +: 16];
    assign w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (rst_n && w_xfer) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_product = {16'd0, r_a} * {16'd0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_id1 <= '0;
            r_ptr <= '0;
        end else if (w_en) begin
            r_v1 <= w_xfer;
            if (w_xfer) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_id1 <= w_grant;
                r_ptr <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else if (w_en) begin
            rsp_valid   <= r_v1;
            rsp_id      <= r_id1;
            rsp_product <= w_product;
        end
    end

`ifdef MUL_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [15:0] r_stat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stat <= '0;
            end else if (req_valid[gi] && req_ready[gi] && (r_stat != 16'hFFFF)) begin
                r_stat <= r_stat + 16'd1;
            end
        end

        assign stat_cnt[16*gi +: 16] = r_stat;
    end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - scoreboard bench for mul_share_arb with a transaction-level reference model
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*16-1:0]  req_a;
    logic [NREQ*16-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_product;
`ifdef MUL_ARB_STATS_EN
    logic [NREQ*16-1:0]  stat_cnt;
`endif

    always #5 clk = ~clk;

    mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
`ifdef MUL_ARB_STATS_EN
        ,
        .stat_cnt    (stat_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Expected responses in acceptance order; the model writes, the monitor reads.
    logic [IDW-1:0] sb_id   [256];
    logic [31:0]    sb_prod [256];
    int             wr = 0;
    int             rd = 0;

    // Reference state: occupancy of the two stages, rotation start, accept counts.
    bit  m_v1;
    bit  m_rv;
    int  m_ptr;
    int  m_cnt [NREQ];
    int  gm_model;
    int  gm_mon;
    logic [NREQ-1:0] exp_rdy;

    bit  end_req  = 1'b0;
    bit  end_done = 1'b0;

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v1  = 1'b0;
            m_rv  = 1'b0;
            m_ptr = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else if (!m_rv || rsp_ready) begin
            gm_model = exp_grant(req_valid, m_ptr);
            m_rv = m_v1;
            m_v1 = (gm_model >= 0);
            if (gm_model >= 0) begin
                sb_id[wr % 256]   = gm_model[IDW-1:0];
                sb_prod[wr % 256] = 32'(req_a[16*gm_model +: 16]) * 32'(req_b[16*gm_model +: 16]);
                wr++;
                m_ptr = (gm_model + 1) % NREQ;
                if (m_cnt[gm_model] < 65535) m_cnt[gm_model]++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rd = wr;
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_id", 64'(rsp_id), 64'(0));
            check("rst_rsp_product", 64'(rsp_product), 64'(0));
            check("rst_req_ready", 64'(req_ready), 64'(0));
        end else begin
            gm_mon  = exp_grant(req_valid, m_ptr);
            exp_rdy = '0;
            if (gm_mon >= 0 && (!m_rv || rsp_ready)) exp_rdy[gm_mon] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            if (rsp_valid) begin
                if (wr == rd) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d product %0h expected no response", rsp_id, rsp_product);
                end else begin
                    check("rsp_id", 64'(rsp_id), 64'(sb_id[rd % 256]));
                    check("rsp_product", 64'(rsp_product), 64'(sb_prod[rd % 256]));
                    if (rsp_ready) rd++;
                end
            end
`ifdef MUL_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) begin
                check("stat_cnt", 64'(stat_cnt[16*i +: 16]), 64'(m_cnt[i]));
            end
`endif
        end
        if (end_req && !end_done) begin
            check("drain_pending", 64'(wr - rd), 64'(0));
            end_done = 1'b1;
        end
    end

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single request from requester 0
        set_op(0, 16'd3, 16'd5);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (4) step();

        // Full contention from reset: grants rotate 0,1,2,3,0,1...
        reset_pulse();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'(i + 1));
        req_valid = '1;
        repeat (8) step();

        // Backpressure with items queued in both stages and a waiting requester
        rsp_ready = 1'b0;
        repeat (5) step();
        rsp_ready = 1'b1;
        repeat (3) step();
        req_valid = '0;
        repeat (3) step();

        // Operand extremes
        set_op(1, 16'hFFFF, 16'hFFFF);
        set_op(2, 16'h0000, 16'hFFFF);
        set_op(3, 16'h8000, 16'h0002);
        req_valid = 4'b1110;
        repeat (3) step();
        req_valid = '0;
        repeat (3) step();

        // Reset with two operations in flight
        req_valid = '1;
        repeat (2) step();
        rsp_ready = 1'b0;
        step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        repeat (4) step();
        req_valid = '0;
        repeat (3) step();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) set_op(i, pick_operand(), pick_operand());
            step();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) step();
        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
